spi_reg_responder: RTL
======================

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 Parameter ADDR_W, default 3: register address width; register count = 2^ADDR_W, each 8 bits.
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 SPI_SCLK  input  1  SPI clock from initiator, asynchronous to clk.
REQ-005 CS  input  1  chip select, active-low, asynchronous to clk.
REQ-006 MOSI  input  1  serial data from initiator, MSB first.
REQ-007 MISO  output  1  serial data to initiator, MSB first.
REQ-008 CPOL, CPHA  input  1 each  SPI mode select; static while CS low.
REQ-009 reg_out  output  8*2^ADDR_W  flat register contents; reg[k] = reg_out[8k+7:8k].
REQ-010 wr_strobe  output  1  one-cycle pulse per register written by SPI.
REQ-011 wr_addr  output  ADDR_W  address of the last write; valid while wr_strobe high, held afterwards.
REQ-012 busy  output  1  high while a transaction is in progress (state not IDLE).

Function
REQ-013 SPI_SCLK, CS and MOSI SHALL each pass a 2-flop synchronizer; edges detected in clk domain; supported SPI_SCLK <= clk/8.
REQ-014 Leading edge = SPI_SCLK leaving CPOL level, trailing edge = returning to it; sample edge = leading if CPHA=0, else trailing; shift edge = the other.
REQ-015 MOSI SHALL be sampled on sample edges; a 3-bit counter tracks bit position; byte complete at 8th sample.
REQ-016 States: IDLE, CMD, WDATA, RDATA, WAIT_CS.
REQ-017 IDLE -> CMD on synchronized CS falling edge; bit counter cleared.
REQ-018 CMD byte: bit7=1 write, 0 read; bits[ADDR_W-1:0] start address; other bits ignored; CMD -> WDATA or RDATA at byte completion; address register loaded.
REQ-019 WDATA: each completed byte written to reg[addr] in the clk cycle after the 8th sample; wr_strobe high that cycle, wr_addr=addr; addr then increments mod 2^ADDR_W.
REQ-020 RDATA: each data byte transmits reg[addr], captured at completion of preceding byte; addr increments mod 2^ADDR_W after capture.
REQ-021 MISO during CMD byte SHALL carry constant 8'hA5; during WDATA bytes 8'h00.
REQ-022 CPHA=0: MSB of first byte on MISO within 4 clk after CS falling edge; each later bit, incl. next byte's MSB, updated on shift edge before its sample edge.
REQ-023 CPHA=1: each bit, incl. every MSB, updated on shift edge preceding its sample edge.
REQ-024 MISO SHALL be 0 while CS high.
REQ-025 CS rising in any state -> IDLE; partial byte discarded, no write, no strobe.
REQ-026 Register write on the same cycle as CS rising after a completed 8th sample SHALL still occur.
REQ-027 Address wrap: reg[2^ADDR_W-1] followed by reg[0] in both directions; transactions unbounded in length.
REQ-028 SPI_SCLK edges while CS high ignored.

Reset
REQ-029 On rst: all registers 8'h00, MISO 0, wr_strobe 0, wr_addr 0, busy 0, counters 0.
REQ-030 If synchronized CS is low when rst deasserts, state SHALL be WAIT_CS (busy 0, all SPI activity ignored) until CS high, then IDLE.
REQ-031 rst mid-transaction: no register written by the aborted byte.

Verification
REQ-032 Mode 0, CS low, MOSI 0x82,0x11,0x22 -> reg2=0x11, reg3=0x22; two wr_strobe pulses wr_addr 2 then 3; MISO byte0 = 0xA5, bytes1-2 = 0x00.
REQ-033 Write reg7=0x77, reg0=0x5A; then read cmd 0x07 + 2 dummy bytes -> MISO 0xA5, 0x77, 0x5A (wrap).
REQ-034 Repeat REQ-032/033 in modes 1, 2, 3 with SPI_SCLK = clk/8 -> identical register and MISO results.
REQ-035 Write cmd 0x81 then CS rises after 5 data bits -> reg1 unchanged, no wr_strobe, busy 0; next transaction correct.
REQ-036 rst pulsed during WDATA with CS low -> all registers 0, busy 0, bytes ignored until CS high then low; next write 0x80,0xFF -> reg0=0xFF.
REQ-037 Two transactions with CS high only 4 clk cycles between -> both decoded correctly.

Source files
------------

// File: rtl/spi_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_responder_if
// Description : SPI pins, mode selects and register-file status of the SPI
//               register responder, grouped for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_responder_if #(
    parameter int ADDR_W = 3
);
    logic                         SPI_SCLK;
    logic                         CS;
    logic                         MOSI;
    logic                         MISO;
    logic                         CPOL;
    logic                         CPHA;
    logic [8*(2**ADDR_W)-1:0]     reg_out;
    logic                         wr_strobe;
    logic [ADDR_W-1:0]            wr_addr;
    logic                         busy;

    // Initiator / observer side
    modport master (
        output SPI_SCLK, CS, MOSI, CPOL, CPHA,
        input  MISO, reg_out, wr_strobe, wr_addr, busy
    );

    // Responder side
    modport slave (
        input  SPI_SCLK, CS, MOSI, CPOL, CPHA,
        output MISO, reg_out, wr_strobe, wr_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_responder
// Description : SPI target exposing 2^ADDR_W 8-bit registers. A command byte
//               (bit7 = write, low bits = start address) is followed by an
//               unbounded stream of data bytes with auto-incrementing address.
//               All four SPI modes; SPI pins are oversampled by clk.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_responder #(
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_responder_if.slave   bus
);

    localparam int         c_num_regs = 2 ** ADDR_W;
    localparam logic [7:0] c_cmd_fill = 8'hA5;
    localparam logic [7:0] c_wr_fill  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RDATA   = 3'd3,
        ST_WAIT_CS = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic r_mosi_meta, r_mosi_sync;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift_in;
    logic [7:0]        r_tx_shift;
    logic              r_miso;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_regs [c_num_regs];

    logic       w_sclk_rise, w_sclk_fall;
    logic       w_lead, w_trail, w_sample, w_shift;
    logic       w_cs_fall, w_cs_rise;
    logic       w_active, w_byte_done;
    logic [7:0] w_rx_byte;

    // Synchronizers run through reset so the CS level is valid when rst drops
    always_ff @(posedge clk) begin
        r_sclk_meta <= bus.SPI_SCLK;
        r_sclk_sync <= r_sclk_meta;
        r_sclk_prev <= r_sclk_sync;
        r_cs_meta   <= bus.CS;
        r_cs_sync   <= r_cs_meta;
        r_cs_prev   <= r_cs_sync;
        r_mosi_meta <= bus.MOSI;
        r_mosi_sync <= r_mosi_meta;
    end

    // MOSI shares the SCLK synchronizer depth, so r_mosi_sync lines up with the edge
    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_lead      = bus.CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = bus.CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = bus.CPHA ? w_trail : w_lead;
    assign w_shift     = bus.CPHA ? w_lead  : w_trail;
    assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
    assign w_cs_rise   = ~r_cs_prev & r_cs_sync;
    assign w_active    = (r_state == ST_CMD) || (r_state == ST_WDATA) || (r_state == ST_RDATA);
    assign w_byte_done = w_active && w_sample && (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_shift_in, r_mosi_sync};

    // State register; reset parks in WAIT_CS so a CS already low is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_CS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; CS rising aborts any active state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_CS: begin
                if (r_cs_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_byte_done) begin
                    w_state_next = w_rx_byte[7] ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift datapath, register file and write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 7'd0;
            r_tx_shift  <= 8'h00;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            for (int k = 0; k < c_num_regs; k++) begin
                r_regs[k] <= 8'h00;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
                if (w_cs_fall) begin
                    // CPHA=0 has no shift edge ahead of the first sample: present the MSB now
                    if (bus.CPHA) begin
                        r_tx_shift <= c_cmd_fill;
                    end else begin
                        r_miso     <= c_cmd_fill[7];
                        r_tx_shift <= {c_cmd_fill[6:0], 1'b0};
                    end
                end
            end else if (w_active) begin
                if (w_cs_rise) begin
                    r_miso <= 1'b0;
                end else if (w_shift) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
                if (w_sample) begin
                    r_shift_in <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                // Byte completion: the next shift edge emits the MSB of the byte loaded here
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: begin
                            if (w_rx_byte[7]) begin
                                r_addr     <= w_rx_byte[ADDR_W-1:0];
                                r_tx_shift <= c_wr_fill;
                            end else begin
                                r_addr     <= w_rx_byte[ADDR_W-1:0] + ADDR_W'(1);
                                r_tx_shift <= r_regs[w_rx_byte[ADDR_W-1:0]];
                            end
                        end
                        ST_WDATA: begin
                            r_regs[r_addr] <= w_rx_byte;
                            r_wr_strobe    <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_addr         <= r_addr + ADDR_W'(1);
                            r_tx_shift     <= c_wr_fill;
                        end
                        default: begin
                            r_tx_shift <= r_regs[r_addr];
                            r_addr     <= r_addr + ADDR_W'(1);
                        end
                    endcase
                end
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < c_num_regs; k++) begin : g_flat
        assign bus.reg_out[8*k +: 8] = r_regs[k];
    end

    // Raw CS gates MISO so the line is quiet as soon as the initiator deselects
    assign bus.MISO      = r_miso & ~bus.CS;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.busy      = w_active;

endmodule
`default_nettype wire
